// File: rtl/shifter_op_sequencer_if.sv
// Shifter-operand sequencer bus: request, Rs read port and result.
// The slave modport is the sequencer's view; master is the driver's.
interface shifter_op_sequencer_if #(
    parameter int DW    = 32,
    parameter int IDX_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_kind;
    logic [11:0]      req_field;
    logic [DW-1:0]    req_rm;
    logic             req_cin;
    logic             rs_req;
    logic [IDX_W-1:0] rs_idx;
    logic             rs_gnt;
    logic             rs_vld;
    logic [DW-1:0]    rs_data;
    logic             res_valid;
    logic             res_ready;
    logic [DW-1:0]    res_data;
    logic             res_carry;

    modport slave (
        input  req_valid, req_kind, req_field, req_rm, req_cin,
        input  rs_gnt, rs_vld, rs_data, res_ready,
        output req_ready, rs_req, rs_idx,
        output res_valid, res_data, res_carry
    );

    modport master (
        output req_valid, req_kind, req_field, req_rm, req_cin,
        output rs_gnt, rs_vld, rs_data, res_ready,
        input  req_ready, rs_req, rs_idx,
        input  res_valid, res_data, res_carry
    );
endinterface

// File: rtl/shifter_op_sequencer.sv
// ARM shifter-operand sequencer: latches a request, fetches Rs if
// needed, computes operand and carry-out, holds it until consumed.
module shifter_op_sequencer #(
    parameter int DW    = 32,
    parameter int IDX_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    shifter_op_sequencer_if.slave bus,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE,
        RSREQ,
        RSWAIT,
        CALC,
        DONE
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [1:0]    kind_q;
    logic [11:0]   field_q;
    logic [31:0]   rm_q;
    logic          cin_q;
    logic [7:0]    amt_q;
    logic [31:0]   data_q;
    logic          carry_q;
    logic          accept;
    logic [31:0]   calc_data;
    logic          calc_carry;
    logic [4:0]    sh_n;
    logic [4:0]    idx_up;
    logic [4:0]    idx_dn;
    logic [4:0]    rot;
    logic [1:0]    sh_type;
    logic          unused_rs_hi;

    function automatic logic [31:0] ror32(
        input logic [31:0] v,
        input logic [4:0]  r
    );
        return (v >> r) | (v << (6'd32 - {1'b0, r}));
    endfunction

    assign accept = bus.req_valid & bus.req_ready;
    assign bus.req_ready = (state_q == IDLE) |
                           ((state_q == DONE) & bus.res_ready);
    assign bus.rs_req    = (state_q == RSREQ);
    assign bus.rs_idx    = IDX_W'(field_q[11:8]);
    assign bus.res_valid = (state_q == DONE);
    assign bus.res_data  = data_q;
    assign bus.res_carry = carry_q;
    assign busy          = (state_q != IDLE);
    assign unused_rs_hi  = ^bus.rs_data[DW-1:8];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; a new accept in DONE skips IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept)
                    state_d = (bus.req_kind == 2'b10) ? RSREQ : CALC;
            end
            RSREQ:  if (bus.rs_gnt) state_d = RSWAIT;
            RSWAIT: if (bus.rs_vld) state_d = CALC;
            CALC:   state_d = DONE;
            DONE: begin
                if (accept)
                    state_d = (bus.req_kind == 2'b10) ? RSREQ : CALC;
                else if (bus.res_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch, Rs amount capture and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kind_q  <= 2'b00;
            field_q <= 12'h000;
            rm_q    <= 32'h0;
            cin_q   <= 1'b0;
            amt_q   <= 8'h00;
            data_q  <= 32'h0;
            carry_q <= 1'b0;
        end else begin
            if (accept) begin
                kind_q  <= bus.req_kind;
                field_q <= bus.req_field;
                rm_q    <= bus.req_rm;
                cin_q   <= bus.req_cin;
            end
            if (state_q == RSWAIT && bus.rs_vld)
                amt_q <= bus.rs_data[7:0];
            if (state_q == CALC) begin
                data_q  <= calc_data;
                carry_q <= calc_carry;
            end
        end
    end

    assign sh_n    = (kind_q == 2'b10) ? amt_q[4:0] : field_q[11:7];
    assign idx_up  = 5'd0 - sh_n;
    assign idx_dn  = sh_n - 5'd1;
    assign rot     = {field_q[11:8], 1'b0};
    assign sh_type = field_q[6:5];

    // Shifter value and carry-out from the latched operands
    always_comb begin
        calc_data  = rm_q;
        calc_carry = cin_q;
        unique case (kind_q)
            2'b00: begin
                calc_data  = ror32({24'd0, field_q[7:0]}, rot);
                calc_carry = (rot == 5'd0) ? cin_q : calc_data[31];
            end
            2'b01: begin
                unique case (sh_type)
                    2'b00: begin
                        if (sh_n != 5'd0) begin
                            calc_data  = rm_q << sh_n;
                            calc_carry = rm_q[idx_up];
                        end
                    end
                    2'b01: begin
                        if (sh_n == 5'd0) begin
                            calc_data  = 32'h0;
                            calc_carry = rm_q[31];
                        end else begin
                            calc_data  = rm_q >> sh_n;
                            calc_carry = rm_q[idx_dn];
                        end
                    end
                    2'b10: begin
                        if (sh_n == 5'd0) begin
                            calc_data  = {32{rm_q[31]}};
                            calc_carry = rm_q[31];
                        end else begin
                            calc_data  = $signed(rm_q) >>> sh_n;
                            calc_carry = rm_q[idx_dn];
                        end
                    end
                    default: begin
                        if (sh_n == 5'd0) begin
                            calc_data  = {cin_q, rm_q[31:1]};
                            calc_carry = rm_q[0];
                        end else begin
                            calc_data  = ror32(rm_q, sh_n);
                            calc_carry = rm_q[idx_dn];
                        end
                    end
                endcase
            end
            2'b10: begin
                if (amt_q != 8'd0) begin
                    unique case (sh_type)
                        2'b00: begin
                            if (amt_q < 8'd32) begin
                                calc_data  = rm_q << sh_n;
                                calc_carry = rm_q[idx_up];
                            end else begin
                                calc_data  = 32'h0;
                                calc_carry = (amt_q == 8'd32) & rm_q[0];
                            end
                        end
                        2'b01: begin
                            if (amt_q < 8'd32) begin
                                calc_data  = rm_q >> sh_n;
                                calc_carry = rm_q[idx_dn];
                            end else begin
                                calc_data  = 32'h0;
                                calc_carry = (amt_q == 8'd32) & rm_q[31];
                            end
                        end
                        2'b10: begin
                            if (amt_q < 8'd32) begin
                                calc_data  = $signed(rm_q) >>> sh_n;
                                calc_carry = rm_q[idx_dn];
                            end else begin
                                calc_data  = {32{rm_q[31]}};
                                calc_carry = rm_q[31];
                            end
                        end
                        default: begin
                            if (sh_n == 5'd0) begin
                                calc_data  = rm_q;
                                calc_carry = rm_q[31];
                            end else begin
                                calc_data  = ror32(rm_q, sh_n);
                                calc_carry = rm_q[idx_dn];
                            end
                        end
                    endcase
                end
            end
            default: begin
                calc_data  = rm_q;
                calc_carry = cin_q;
            end
        endcase
    end

endmodule

// File: tb/tb_shifter_op_sequencer.sv
// Directed bench for shifter_op_sequencer.
// Each test task drives one scenario and checks inline.
module tb_shifter_op_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   total = 0;
    int   bad = 0;

    shifter_op_sequencer_if #(.DW(32), .IDX_W(4)) bus ();

    shifter_op_sequencer #(.DW(32), .IDX_W(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave),
        .busy (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        bus.req_valid = 1'b0;
        bus.req_kind  = 2'b00;
        bus.req_field = 12'h000;
        bus.req_rm    = 32'h0;
        bus.req_cin   = 1'b0;
        bus.rs_gnt    = 1'b0;
        bus.rs_vld    = 1'b0;
        bus.rs_data   = 32'h0;
        bus.res_ready = 1'b0;
    endtask

    // Present one request from IDLE, then scramble the inputs
    task automatic send(input logic [1:0] k, input logic [11:0] f,
                        input logic [31:0] rm, input logic cin);
        @(negedge clk);
        bus.req_kind  = k;
        bus.req_field = f;
        bus.req_rm    = rm;
        bus.req_cin   = cin;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_field = ~f;
        bus.req_rm    = ~rm;
        bus.req_cin   = ~cin;
    endtask

    task automatic consume();
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        #12;
        total++;
        if ({busy, bus.rs_req, bus.res_valid} !== 3'b000) begin
            bad++;
            $display("FAIL reset_ctl got=%b want=000",
                     {busy, bus.rs_req, bus.res_valid});
        end
        total++;
        if ({bus.res_data, bus.res_carry} !== 33'h0) begin
            bad++;
            $display("FAIL reset_res got=%h/%b want=0/0",
                     bus.res_data, bus.res_carry);
        end
        total++;
        if (bus.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b want=1", bus.req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_imm_rotate();
        send(2'b00, 12'h4FF, 32'h0, 1'b0);
        @(negedge clk);
        total++;
        if ({bus.res_valid, busy} !== 2'b01) begin
            bad++;
            $display("FAIL imm_calc_cycle got=%b want=01",
                     {bus.res_valid, busy});
        end
        @(negedge clk);
        total++;
        if (bus.res_valid !== 1'b1 ||
            bus.res_data !== 32'hFF000000 ||
            bus.res_carry !== 1'b1) begin
            bad++;
            $display("FAIL imm_rot got=%b/%h/%b want=1/ff000000/1",
                     bus.res_valid, bus.res_data, bus.res_carry);
        end
        consume();
    endtask

    task automatic test_shift_imm();
        logic [11:0] fv [4];
        logic [31:0] rv [4];
        logic        cv [4];
        logic [31:0] ed [4];
        logic        ec [4];
        fv = '{12'h020, 12'h060, 12'h100, 12'h240};
        rv = '{32'h80000001, 32'h3, 32'hC0000001, 32'h80000010};
        cv = '{1'b0, 1'b1, 1'b0, 1'b1};
        ed = '{32'h0, 32'h80000001, 32'h4, 32'hF8000001};
        ec = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            send(2'b01, fv[i], rv[i], cv[i]);
            @(negedge clk);
            @(negedge clk);
            total++;
            if (bus.res_valid !== 1'b1 ||
                bus.res_data !== ed[i] ||
                bus.res_carry !== ec[i]) begin
                bad++;
                $display("FAIL shift_imm[%0d] got=%b/%h/%b want=1/%h/%b",
                         i, bus.res_valid, bus.res_data,
                         bus.res_carry, ed[i], ec[i]);
            end
            consume();
        end
    endtask

    task automatic test_reg_delayed_grant();
        send(2'b10, 12'h310, 32'h1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (bus.rs_req !== 1'b1 || bus.rs_idx !== 4'd3) begin
                bad++;
                $display("FAIL rs_hold[%0d] got=%b/%0d want=1/3",
                         i, bus.rs_req, bus.rs_idx);
            end
        end
        bus.rs_gnt = 1'b1;
        @(posedge clk);
        #1;
        bus.rs_gnt = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.rs_req, busy} !== 2'b01) begin
            bad++;
            $display("FAIL rs_drop got=%b want=01", {bus.rs_req, busy});
        end
        bus.rs_vld  = 1'b1;
        bus.rs_data = 32'h20;
        @(posedge clk);
        #1;
        bus.rs_vld  = 1'b0;
        bus.rs_data = 32'hFFFFFFFF;
        @(negedge clk);
        total++;
        if (bus.res_valid !== 1'b0) begin
            bad++;
            $display("FAIL reg_calc_cycle got=%b want=0", bus.res_valid);
        end
        @(negedge clk);
        total++;
        if (bus.res_valid !== 1'b1 ||
            bus.res_data !== 32'h0 ||
            bus.res_carry !== 1'b1) begin
            bad++;
            $display("FAIL reg_lsl32 got=%b/%h/%b want=1/00000000/1",
                     bus.res_valid, bus.res_data, bus.res_carry);
        end
        consume();
    endtask

    task automatic test_shift_reg();
        logic [11:0] fv [7];
        logic [31:0] rv [7];
        logic        cv [7];
        logic [31:0] sv [7];
        logic [31:0] ed [7];
        logic        ec [7];
        fv = '{12'h370, 12'h370, 12'h330, 12'h350,
               12'h330, 12'h310, 12'h370};
        rv = '{32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,
               32'h000000F8, 32'hFFFFFFFF, 32'h0000000F};
        cv = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        sv = '{32'h40, 32'h100, 32'h21, 32'h28, 32'h4, 32'h21, 32'h24};
        ed = '{32'h80000000, 32'h80000000, 32'h0, 32'hFFFFFFFF,
               32'h0000000F, 32'h0, 32'hF0000000};
        ec = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            send(2'b10, fv[i], rv[i], cv[i]);
            @(negedge clk);
            bus.rs_gnt = 1'b1;
            @(posedge clk);
            #1;
            bus.rs_gnt = 1'b0;
            @(negedge clk);
            bus.rs_vld  = 1'b1;
            bus.rs_data = sv[i];
            @(posedge clk);
            #1;
            bus.rs_vld  = 1'b0;
            bus.rs_data = 32'h0;
            @(negedge clk);
            @(negedge clk);
            total++;
            if (bus.res_valid !== 1'b1 ||
                bus.res_data !== ed[i] ||
                bus.res_carry !== ec[i]) begin
                bad++;
                $display("FAIL shift_reg[%0d] got=%b/%h/%b want=1/%h/%b",
                         i, bus.res_valid, bus.res_data,
                         bus.res_carry, ed[i], ec[i]);
            end
            consume();
        end
    endtask

    task automatic test_back_to_back();
        send(2'b11, 12'h000, 32'h12345678, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (bus.res_valid !== 1'b1 ||
                bus.res_data !== 32'h12345678 ||
                bus.res_carry !== 1'b1 ||
                bus.req_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold[%0d] got=%b/%h/%b rdy=%b want=1/12345678/1 rdy=0",
                         i, bus.res_valid, bus.res_data,
                         bus.res_carry, bus.req_ready);
            end
            if (i == 0) begin
                bus.req_kind  = 2'b00;
                bus.req_field = 12'h0AB;
                bus.req_rm    = 32'h0;
                bus.req_cin   = 1'b0;
                bus.req_valid = 1'b1;
            end
        end
        bus.res_ready = 1'b1;
        #1;
        total++;
        if (bus.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready got=%b want=1", bus.req_ready);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.res_ready = 1'b0;
        bus.req_field = 12'hFFF;
        @(negedge clk);
        total++;
        if ({bus.res_valid, busy} !== 2'b01) begin
            bad++;
            $display("FAIL b2b_calc got=%b want=01", {bus.res_valid, busy});
        end
        @(negedge clk);
        total++;
        if (bus.res_valid !== 1'b1 ||
            bus.res_data !== 32'h000000AB ||
            bus.res_carry !== 1'b0) begin
            bad++;
            $display("FAIL b2b_res got=%b/%h/%b want=1/000000ab/0",
                     bus.res_valid, bus.res_data, bus.res_carry);
        end
        consume();
    endtask

    task automatic test_reset_abort();
        send(2'b10, 12'h310, 32'h1, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.rs_req, busy} !== 2'b00) begin
            bad++;
            $display("FAIL rst_rsreq got=%b want=00", {bus.rs_req, busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
        send(2'b10, 12'h310, 32'h1, 1'b0);
        @(negedge clk);
        bus.rs_gnt = 1'b1;
        @(posedge clk);
        #1;
        bus.rs_gnt = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.rs_req, bus.res_valid, busy} !== 3'b000 ||
            bus.res_data !== 32'h0) begin
            bad++;
            $display("FAIL rst_rswait got=%b/%h want=000/00000000",
                     {bus.rs_req, bus.res_valid, busy}, bus.res_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.rs_vld  = 1'b1;
        bus.rs_data = 32'h20;
        @(posedge clk);
        #1;
        bus.rs_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({bus.res_valid, busy} !== 2'b00) begin
                bad++;
                $display("FAIL stray_vld[%0d] got=%b want=00",
                         i, {bus.res_valid, busy});
            end
        end
    endtask

    initial begin
        test_reset();
        test_imm_rotate();
        test_shift_imm();
        test_reg_delayed_grant();
        test_shift_reg();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
